// File: rtl/axi4l_reg_slave_pkg.sv
// Shared types and helpers for axi4l_reg_slave.
// Define AXI4L_REG_SLAVE_DECERR_EN to answer unmapped addresses with DECERR instead of OKAY.
package axi4l_reg_slave_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE      = 2'd0;
    localparam wr_state_t W_ADDR_HELD = 2'd1;
    localparam wr_state_t W_DATA_HELD = 2'd2;
    localparam wr_state_t W_RESP      = 2'd3;

    typedef logic rd_state_t;
    localparam rd_state_t R_IDLE = 1'b0;
    localparam rd_state_t R_DATA = 1'b1;

`ifdef AXI4L_REG_SLAVE_DECERR_EN
    localparam resp_t OOR_RESP = DECERR;
`else
    localparam resp_t OOR_RESP = OKAY;
`endif

    // Full word index; callers compare it against NUM_REGS for the range check.
    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input int unsigned addr_lsb);
        return addr >> addr_lsb;
    endfunction

endpackage

// File: rtl/axi4l_reg_slave_if.sv
// AXI4-Lite bundle between a manager and axi4l_reg_slave.
interface axi4l_reg_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axi4l_reg_slave_wr_ctrl.sv
// Write-channel FSM: captures AW and W in either order and issues one commit plus the B response.
module axi4l_reg_slave_wr_ctrl
    import axi4l_reg_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [ADDR_WIDTH-1:0]         i_awaddr,
    input  logic                          i_awvalid,
    output logic                          o_awready,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic [DATA_WIDTH/8-1:0]       i_wstrb,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    output logic [1:0]                    o_bresp,
    output logic                          o_bvalid,
    input  logic                          i_bready,
    output logic                          o_wr_en,
    output logic [$clog2(NUM_REGS)-1:0]   o_wr_idx,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    output logic [DATA_WIDTH/8-1:0]       o_wr_strb
);
    localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    wr_state_t               r_state, w_state_d;
    logic                    r_awready, r_wready, r_bvalid;
    resp_t                   r_bresp, w_bresp_d;
    logic [ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_d, w_cmt_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
    logic [DATA_WIDTH/8-1:0] r_wstrb, w_wstrb_d;
    logic                    w_aw_hs, w_w_hs, w_commit, w_in_range;
    logic [63:0]             w_word;

    assign w_aw_hs    = i_awvalid & r_awready;
    assign w_w_hs     = i_wvalid & r_wready;
    // A live handshake beats the held copy: the held side is only ever the other channel.
    assign w_cmt_addr = w_aw_hs ? i_awaddr : r_awaddr;
    assign w_word     = addr_to_idx(64'(w_cmt_addr), ADDR_LSB);
    assign w_in_range = w_word < 64'(NUM_REGS);

    always_comb begin
        w_state_d  = r_state;
        w_commit   = 1'b0;
        w_awaddr_d = r_awaddr;
        w_wdata_d  = r_wdata;
        w_wstrb_d  = r_wstrb;
        case (r_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit  = 1'b1;
                    w_state_d = W_RESP;
                end else if (w_aw_hs) begin
                    w_awaddr_d = i_awaddr;
                    w_state_d  = W_ADDR_HELD;
                end else if (w_w_hs) begin
                    w_wdata_d = i_wdata;
                    w_wstrb_d = i_wstrb;
                    w_state_d = W_DATA_HELD;
                end
            end
            W_ADDR_HELD: if (w_w_hs) begin
                w_commit  = 1'b1;
                w_state_d = W_RESP;
            end
            W_DATA_HELD: if (w_aw_hs) begin
                w_commit  = 1'b1;
                w_state_d = W_RESP;
            end
            W_RESP:  if (i_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        w_bresp_d = r_bresp;
        if (w_commit) w_bresp_d = w_in_range ? OKAY : OOR_RESP;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_awready <= (w_state_d == W_IDLE) || (w_state_d == W_DATA_HELD);
            r_wready  <= (w_state_d == W_IDLE) || (w_state_d == W_ADDR_HELD);
            r_bvalid  <= (w_state_d == W_RESP);
            r_bresp   <= w_bresp_d;
            r_awaddr  <= w_awaddr_d;
            r_wdata   <= w_wdata_d;
            r_wstrb   <= w_wstrb_d;
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_wr_en   = w_commit & w_in_range;
    assign o_wr_idx  = w_word[IDX_W-1:0];
    assign o_wr_data = w_w_hs ? i_wdata : r_wdata;
    assign o_wr_strb = w_w_hs ? i_wstrb : r_wstrb;

endmodule

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS byte-writable registers plus the read path.
// AXI4L_REG_SLAVE_DECERR_EN makes unmapped accesses answer DECERR.
module axi4l_reg_slave
    import axi4l_reg_slave_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 4,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                           axi4l_aclk,
    input  logic                           axi4l_arstn,
    axi4l_reg_slave_if.slave               s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr
);
    localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic                    w_wr_en;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [DATA_WIDTH/8-1:0] w_wr_strb;
    logic [NUM_REGS-1:0]     w_hit;

    axi4l_reg_slave_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_ctrl (
        .i_clk     (axi4l_aclk),
        .i_rst_n   (axi4l_arstn),
        .i_awaddr  (s_axi.s_awaddr),
        .i_awvalid (s_axi.s_awvalid),
        .o_awready (s_axi.s_awready),
        .i_wdata   (s_axi.s_wdata),
        .i_wstrb   (s_axi.s_wstrb),
        .i_wvalid  (s_axi.s_wvalid),
        .o_wready  (s_axi.s_wready),
        .o_bresp   (s_axi.s_bresp),
        .o_bvalid  (s_axi.s_bvalid),
        .i_bready  (s_axi.s_bready),
        .o_wr_en   (w_wr_en),
        .o_wr_idx  (w_wr_idx),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_hit[g] = w_wr_en && (w_wr_idx == IDX_W'(g));
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
    assign reg_wr = w_hit;

    always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
        if (!axi4l_arstn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_hit[i]) begin
                    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                        if (w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    rd_state_t             r_rd_state, w_rd_state_d;
    logic                  r_arready, r_rvalid, w_ar_in_range;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
    resp_t                 r_rresp, w_rresp_d;
    logic [63:0]           w_ar_word;
    logic [IDX_W-1:0]      w_ar_idx;

    assign w_ar_word     = addr_to_idx(64'(s_axi.s_araddr), ADDR_LSB);
    assign w_ar_in_range = w_ar_word < 64'(NUM_REGS);
    assign w_ar_idx      = w_ar_word[IDX_W-1:0];

    // Read samples r_regs before this cycle's write lands, so a colliding read sees the old value.
    always_comb begin
        w_rd_state_d = r_rd_state;
        w_rdata_d    = r_rdata;
        w_rresp_d    = r_rresp;
        case (r_rd_state)
            R_IDLE: if (s_axi.s_arvalid && r_arready) begin
                w_rd_state_d = R_DATA;
                w_rdata_d    = w_ar_in_range ? r_regs[w_ar_idx] : '0;
                w_rresp_d    = w_ar_in_range ? OKAY : OOR_RESP;
            end
            R_DATA:  if (s_axi.s_rready) w_rd_state_d = R_IDLE;
            default: w_rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
        if (!axi4l_arstn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            r_rd_state <= w_rd_state_d;
            r_arready  <= (w_rd_state_d == R_IDLE);
            r_rvalid   <= (w_rd_state_d == R_DATA);
            r_rdata    <= w_rdata_d;
            r_rresp    <= w_rresp_d;
        end
    end

    assign s_axi.s_arready = r_arready;
    assign s_axi.s_rvalid  = r_rvalid;
    assign s_axi.s_rdata   = r_rdata;
    assign s_axi.s_rresp   = r_rresp;

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Directed bench for axi4l_reg_slave: vector table plus ordering/backpressure/collision sequences.
module tb_axi4l_reg_slave;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int NV = 14;
`ifdef AXI4L_REG_SLAVE_DECERR_EN
    localparam logic [1:0] OOR = 2'b11;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic             clk = 1'b0;
    logic             arstn = 1'b0;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    reg_wr;

    axi4l_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4l_reg_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .axi4l_aclk  (clk),
        .axi4l_arstn (arstn),
        .s_axi       (bus.slave),
        .reg_out     (reg_out),
        .reg_wr      (reg_wr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  regwr;
    } vec_t;

    vec_t vecs [NV];

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [3:0] wr_seen,
                            output int lat);
        int n;
        resp = 'x; wr_seen = 'x; lat = -1;
        @(posedge clk); #1;
        bus.s_awaddr = a; bus.s_awvalid = 1'b1;
        bus.s_wdata = d; bus.s_wstrb = s; bus.s_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.s_awready && bus.s_wready) && n < 20);
        check("wr_aw_w_ready", 64'({bus.s_awready, bus.s_wready}), 64'(2'b11));
        wr_seen = reg_wr;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_bvalid && n < 20);
        lat = n; resp = bus.s_bresp;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int n;
        d = 'x; resp = 'x; lat = -1;
        @(posedge clk); #1;
        bus.s_araddr = a; bus.s_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_arready && n < 20);
        check("rd_ar_ready", 64'(bus.s_arready), 64'(1));
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_rvalid && n < 20);
        lat = n; d = bus.s_rdata; resp = bus.s_rresp;
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  wrs;
        logic [31:0] rd;
        int          lat;

        vecs[0]  = '{1'b0, 32'h0,   32'h0,        4'h0, 2'b00, 32'h0,        4'b0000};
        vecs[1]  = '{1'b0, 32'h4,   32'h0,        4'h0, 2'b00, 32'h0,        4'b0000};
        vecs[2]  = '{1'b0, 32'h8,   32'h0,        4'h0, 2'b00, 32'h0,        4'b0000};
        vecs[3]  = '{1'b0, 32'hC,   32'h0,        4'h0, 2'b00, 32'h0,        4'b0000};
        vecs[4]  = '{1'b1, 32'h4,   32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        4'b0010};
        vecs[5]  = '{1'b0, 32'h4,   32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 4'b0000};
        vecs[6]  = '{1'b1, 32'hC,   32'hFFFFFFFF, 4'h5, 2'b00, 32'h0,        4'b1000};
        vecs[7]  = '{1'b0, 32'hC,   32'h0,        4'h0, 2'b00, 32'h00FF00FF, 4'b0000};
        vecs[8]  = '{1'b1, 32'h10,  32'hA5A5A5A5, 4'hF, OOR,   32'h0,        4'b0000};
        vecs[9]  = '{1'b0, 32'h10,  32'h0,        4'h0, OOR,   32'h0,        4'b0000};
        vecs[10] = '{1'b1, 32'h7,   32'h11223344, 4'hC, 2'b00, 32'h0,        4'b0010};
        vecs[11] = '{1'b0, 32'h5,   32'h0,        4'h0, 2'b00, 32'h1122BEEF, 4'b0000};
        vecs[12] = '{1'b1, 32'h100, 32'h77777777, 4'hF, OOR,   32'h0,        4'b0000};
        vecs[13] = '{1'b0, 32'h0,   32'h0,        4'h0, 2'b00, 32'h0,        4'b0000};

        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'(0));
        check("rst_valid", 64'({bus.s_bvalid, bus.s_rvalid}), 64'(0));
        check("rst_resp", 64'({bus.s_bresp, bus.s_rresp}), 64'(0));
        check("rst_rdata", 64'(bus.s_rdata), 64'(0));
        check("rst_reg_wr", 64'(reg_wr), 64'(0));
        check("rst_reg_out_lo", reg_out[63:0], 64'(0));
        check("rst_reg_out_hi", reg_out[127:64], 64'(0));
        #2 arstn = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, wrs, lat);
                check($sformatf("v%0d_bresp", i), 64'(resp), 64'(vecs[i].resp));
                check($sformatf("v%0d_reg_wr", i), 64'(wrs), 64'(vecs[i].regwr));
                check($sformatf("v%0d_b_latency", i), 64'(lat), 64'(1));
            end else begin
                do_read(vecs[i].addr, rd, resp, lat);
                check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].rdata));
                check($sformatf("v%0d_rresp", i), 64'(resp), 64'(vecs[i].resp));
                check($sformatf("v%0d_r_latency", i), 64'(lat), 64'(1));
            end
        end
        check("tbl_reg0", 64'(reg_out[31:0]), 64'(32'h0));
        check("tbl_reg1", 64'(reg_out[63:32]), 64'(32'h1122BEEF));
        check("tbl_reg2", 64'(reg_out[95:64]), 64'(32'h0));
        check("tbl_reg3", 64'(reg_out[127:96]), 64'(32'h00FF00FF));

        // W arrives three cycles ahead of AW
        @(posedge clk); #1;
        bus.s_wdata = 32'h12345678; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        @(negedge clk);
        check("wfirst_wready", 64'(bus.s_wready), 64'(1));
        @(posedge clk); #1;
        bus.s_wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wfirst_hold", 64'({bus.s_bvalid, bus.s_wready, bus.s_awready, reg_wr}),
                  64'(7'b0010000));
        end
        @(posedge clk); #1;
        bus.s_awaddr = 32'h8; bus.s_awvalid = 1'b1;
        @(negedge clk);
        check("wfirst_commit", 64'({bus.s_awready, reg_wr}), 64'(5'b10100));
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
        @(negedge clk);
        check("wfirst_b", 64'({bus.s_bvalid, bus.s_bresp, reg_wr}), 64'(7'b1000000));
        check("wfirst_reg2", 64'(reg_out[95:64]), 64'(32'h12345678));
        @(posedge clk); #1 bus.s_bready = 1'b1;
        @(posedge clk); #1 bus.s_bready = 1'b0;

        // B backpressure with a second write queued behind it
        @(posedge clk); #1;
        bus.s_awaddr = 32'h0; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'hCAFEF00D; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        @(negedge clk);
        check("bp_first_ready", 64'({bus.s_awready, bus.s_wready}), 64'(2'b11));
        @(posedge clk); #1;
        bus.s_awaddr = 32'h4; bus.s_wdata = 32'h55667788;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_b_stable", 64'({bus.s_bvalid, bus.s_bresp}), 64'(3'b100));
            check("bp_ready_low", 64'({bus.s_awready, bus.s_wready}), 64'(0));
            check("bp_reg1_held", 64'(reg_out[63:32]), 64'(32'h1122BEEF));
        end
        @(posedge clk); #1 bus.s_bready = 1'b1;
        @(negedge clk);
        check("bp_b_before_hs", 64'({bus.s_bvalid, bus.s_awready}), 64'(2'b10));
        @(posedge clk); #1 bus.s_bready = 1'b0;
        @(negedge clk);
        check("bp_after_hs", 64'({bus.s_bvalid, bus.s_awready, bus.s_wready}), 64'(3'b011));
        check("bp_reg0", 64'(reg_out[31:0]), 64'(32'hCAFEF00D));
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        @(negedge clk);
        check("bp_second_b", 64'(bus.s_bvalid), 64'(1));
        check("bp_reg1", 64'(reg_out[63:32]), 64'(32'h55667788));
        @(posedge clk); #1 bus.s_bready = 1'b1;
        @(posedge clk); #1 bus.s_bready = 1'b0;

        // Read and write to reg 2 in the same cycle
        @(posedge clk); #1;
        bus.s_awaddr = 32'h8; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h9ABCDEF0; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        bus.s_araddr = 32'h8; bus.s_arvalid = 1'b1;
        @(negedge clk);
        check("coll_ready", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'(3'b111));
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b1; bus.s_bready = 1'b1;
        @(negedge clk);
        check("coll_rdata_old", 64'(bus.s_rdata), 64'(32'h12345678));
        check("coll_valids", 64'({bus.s_rvalid, bus.s_bvalid, bus.s_arready}), 64'(3'b110));
        check("coll_reg2_new", 64'(reg_out[95:64]), 64'(32'h9ABCDEF0));
        @(posedge clk); #1;
        bus.s_rready = 1'b0; bus.s_bready = 1'b0;
        @(negedge clk);
        check("coll_done", 64'({bus.s_rvalid, bus.s_bvalid}), 64'(0));

        // Asynchronous reset mid-cycle
        @(posedge clk); #3 arstn = 1'b0;
        #1;
        check("arst_reg_out_lo", reg_out[63:0], 64'(0));
        check("arst_reg_out_hi", reg_out[127:64], 64'(0));
        check("arst_ready", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'(0));
        #10 arstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
